// File: rtl/mcu_pkg.sv
// Shared constants for the memory control unit, the cores and the DRAM arbiter.
// This package also holds the arbiter state encoding.
package mcu_pkg;

  localparam int MCU_NUM_CORES = 4;
  localparam int MCU_ADDR_W    = 16;
  localparam int MCU_DATA_W    = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_DONE  = S_DONE
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the first set request scanning from i_ptr upward,
// modulo N. Purely combinational.
module rr_pick
  import mcu_pkg::*;
#(
  parameter int N    = MCU_NUM_CORES,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_id
);

  int              idx;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      sel = ID_W'(idx);
      if (!found && i_req[sel]) begin
        found      = 1'b1;
        o_gnt[sel] = 1'b1;
        o_id       = sel;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter that gives the cores one at a time access to a shared
// single-port data RAM, returning read data and a per-core acknowledge.
module dram_arbiter
  import mcu_pkg::*;
#(
  parameter int NUM_CORES = MCU_NUM_CORES,
  parameter int ADDR_W    = MCU_ADDR_W,
  parameter int DATA_W    = MCU_DATA_W,
  parameter int MEM_LAT   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES-1:0]        i_we,
  input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
  input  logic [NUM_CORES*DATA_W-1:0] i_wdata,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic [NUM_CORES-1:0]        o_ack,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_busy,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  output logic                        o_mem_read,
  output logic                        o_mem_write,
  input  logic [DATA_W-1:0]           i_mem_rdata
);

  // state | meaning
  // IDLE  | no owner; arbitrate and latch the winner's request
  // ISSUE | one-cycle RAM strobe for the latched request
  // WAIT  | read latency countdown; capture RAM data at zero
  // DONE  | acknowledge the owner, advance the round-robin pointer

  localparam int ID_W  = id_width(NUM_CORES);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_CORES - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_CORES-1:0] pick_gnt;
  logic [ID_W-1:0]      pick_id;
  logic [NUM_CORES-1:0] id_oh;

  rr_pick #(
    .N    (NUM_CORES),
    .ID_W (ID_W)
  ) u_rr_pick (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (pick_gnt),
    .o_id  (pick_id)
  );

  assign id_oh = NUM_CORES'(1) << id_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    o_gnt       = '0;
    o_ack       = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          id_d = pick_id;
          for (int k = 0; k < NUM_CORES; k++) begin
            if (pick_gnt[k]) begin
              we_d    = i_we[k];
              addr_d  = i_addr[k*ADDR_W +: ADDR_W];
              wdata_d = i_wdata[k*DATA_W +: DATA_W];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_gnt       = id_oh;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        o_mem_write = we_q;
        o_mem_read  = ~we_q;
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_gnt       = id_oh;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          rdata_d = i_mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        o_gnt       = id_oh;
        o_ack       = id_oh;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        // Pointer moves past the core just served so it loses priority next round.
        ptr_d       = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_rdata = rdata_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a transaction-level model (cycle offsets from the
// arbitration cycle) is compared with the DUT every cycle, plus literal checks.
module tb_dram_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NC-1:0]    req, we;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC-1:0]    gnt, ack;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic [AW-1:0]    maddr;
  logic [DW-1:0]    mwdata;
  logic             mread, mwrite;
  logic [DW-1:0]    mrdata;

  dram_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (gnt),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_mem_addr  (maddr),
    .o_mem_wdata (mwdata),
    .o_mem_read  (mread),
    .o_mem_write (mwrite),
    .i_mem_rdata (mrdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // RAM environment
  logic [7:0] ram    [256];
  logic [7:0] rd_buf [8];
  int         rd_cyc [8];

  // reference model
  bit         m_valid, m_active, m_we;
  int         m_t, m_id, m_ptr;
  logic [15:0] m_addr;
  logic [7:0] m_wdata, m_rdata, m_exp_rd;
  logic [7:0] m_ram [256];

  int ack_log[$];
  bit sticky;
  int age [NC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int ack_at();
    return m_we ? 2 : 2 + LAT;
  endfunction

  task automatic post(input int k, input bit w, input logic [15:0] a, input logic [7:0] d);
    req[k] = 1'b1;
    we[k]  = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    age[k] = 0;
  endtask

  task automatic compare();
    logic [3:0] e_gnt, e_ack;
    logic       e_rd, e_wr;
    logic [7:0] e_rdata;
    if (!m_valid) return;
    e_gnt = '0; e_ack = '0; e_rd = 1'b0; e_wr = 1'b0; e_rdata = m_rdata;
    if (m_active) begin
      e_gnt = 4'(1) << m_id;
      if (m_t == ack_at()) begin
        e_ack = e_gnt;
        if (!m_we) e_rdata = m_exp_rd;
      end
      e_wr = (m_t == 1) && m_we;
      e_rd = (m_t == 1) && !m_we;
      if (m_t < ack_at()) chk("mem_addr", maddr, m_addr);
      if (m_t == 1) chk("mem_wdata", mwdata, m_wdata);
    end
    chk("gnt", gnt, e_gnt);
    chk("ack", ack, e_ack);
    chk("rdata", rdata, e_rdata);
    chk("busy", busy, m_active);
    chk("mem_read", mread, e_rd);
    chk("mem_write", mwrite, e_wr);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("one_strobe", mread & mwrite, 0);
  endtask

  task automatic model_step();
    int idx, j;
    if (m_valid && m_active && m_t == 1) begin
      if (m_we) m_ram[m_addr[7:0]] = m_wdata;
      else      m_exp_rd = m_ram[m_addr[7:0]];
    end
    if (rst) begin
      m_valid = 1; m_active = 0; m_ptr = 0; m_rdata = '0;
      return;
    end
    if (!m_valid) return;
    if (!m_active) begin
      if (req != '0) begin
        idx = -1;
        for (int i = 0; i < NC; i++) begin
          j = (m_ptr + i) % NC;
          if (idx < 0 && req[j]) idx = j;
        end
        m_id = idx; m_we = we[idx];
        m_addr = addr[idx*AW +: AW]; m_wdata = wdata[idx*DW +: DW];
        m_active = 1; m_t = 1;
      end
    end else if (m_t == ack_at()) begin
      m_active = 0;
      m_ptr = (m_id + 1) % NC;
      if (!m_we) m_rdata = m_exp_rd;
    end else begin
      m_t++;
    end
  endtask

  task automatic env_step();
    if (m_valid) begin
      if (mwrite === 1'b1) ram[maddr[7:0]] = mwdata;
      if (mread === 1'b1) begin
        rd_buf[(cyc + LAT) % 8] = ram[maddr[7:0]];
        rd_cyc[(cyc + LAT) % 8] = cyc + LAT;
      end
    end
    if (rd_cyc[cyc % 8] == cyc) mrdata = rd_buf[cyc % 8];
    else                        mrdata = 8'($urandom);
  endtask

  task automatic tick();
    env_step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
    for (int k = 0; k < NC; k++) begin
      if (m_valid && ack[k] === 1'b1) begin
        ack_log.push_back(k);
        if (sticky) post(k, 1'($urandom), 16'($urandom), 8'($urandom));
        else        req[k] = 1'b0;
        age[k] = 0;
      end
      if (req[k]) begin
        age[k]++;
        if (age[k] > 40) begin
          n_cmp++; n_bad++;
          $display("FAIL starve core %0d at cycle %0d: waited %0d cycles, limit 40", k, cyc, age[k]);
          age[k] = 0;
        end
      end else begin
        age[k] = 0;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((req != '0 || busy !== 1'b0) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout at cycle %0d: req %0h busy %0b after %0d cycles", cyc, req, busy, n);
    end
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    req = '0; we = '0; addr = '0; wdata = '0; rst = 1'b1; mrdata = '0; sticky = 0;
    m_valid = 0; m_active = 0; m_we = 0; m_t = 0; m_id = 0; m_ptr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_exp_rd = '0;
    for (int i = 0; i < NC; i++) age[i] = 0;
    for (int i = 0; i < 8; i++) begin rd_cyc[i] = -1; rd_buf[i] = '0; end
    for (int i = 0; i < 256; i++) begin ram[i] = 8'($urandom); m_ram[i] = ram[i]; end

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {mread, mwrite}, 0);

    // single write, core 2
    post(2, 1'b1, 16'h0105, 8'hA5);
    tick();
    chk("w_write", mwrite, 1);
    chk("w_addr", maddr, 16'h0105);
    chk("w_wdata", mwdata, 8'hA5);
    chk("w_gnt", gnt, 4'b0100);
    tick();
    chk("w_ack", ack, 4'b0100);
    tick();
    chk("w_idle", busy, 0);

    // single read, core 1
    ram[8'h10] = 8'h3C; m_ram[8'h10] = 8'h3C;
    post(1, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("r_strobe", mread, 1);
    chk("r_gnt", gnt, 4'b0010);
    tick();
    chk("r_strobe_once", mread, 0);
    tick();
    chk("r_no_ack_yet", ack, 0);
    tick();
    chk("r_ack", ack, 4'b0010);
    chk("r_rdata", rdata, 8'h3C);
    tick();

    // core 3 write leaves read data alone, then pointer wraps to core 0
    post(3, 1'b1, 16'h0200, 8'h11);
    tick(); tick();
    chk("w3_ack", ack, 4'b1000);
    chk("w_keeps_rdata", rdata, 8'h3C);
    ack_log.delete();
    post(0, 1'b1, 16'h0201, 8'h12);
    post(3, 1'b1, 16'h0202, 8'h13);
    tick(); tick();
    chk("wrap_first", gnt, 4'b0001);
    drain(50);
    chk("wrap_n", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      chk("wrap_order0", ack_log[0], 0);
      chk("wrap_order1", ack_log[1], 3);
    end

    // contention from reset
    rst = 1'b1; tick(); rst = 1'b0;
    ack_log.delete();
    sticky = 1;
    for (int k = 0; k < NC; k++) post(k, 1'($urandom), 16'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++) tick();
    sticky = 0;
    drain(100);
    chk("cont_n", ack_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) chk("cont_order", ack_log[i], exp_order[i]);

    // reset while a read waits; pointer must come back to 0
    post(1, 1'b1, 16'h0300, 8'h22);
    drain(50);
    post(1, 1'b0, 16'h0301, 8'h00);
    tick(); tick();
    chk("rw_in_wait", busy, 1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_gnt", gnt, 0);
    chk("rw_ack", ack, 0);
    chk("rw_rdata", rdata, 0);
    ack_log.delete();
    post(1, 1'b1, 16'h0302, 8'h23);
    post(3, 1'b1, 16'h0303, 8'h24);
    tick(); tick();
    chk("rw_ptr_gnt", gnt, 4'b0010);
    drain(50);
    chk("rw_acks", ack_log.size(), 2);
    if (ack_log.size() >= 2) chk("rw_second", ack_log[1], 3);

    // request withdrawn during ISSUE
    post(0, 1'b1, 16'h0400, 8'h33);
    tick();
    chk("wd_issue", gnt, 4'b0001);
    req[0] = 1'b0;
    tick();
    chk("wd_ack", ack, 4'b0001);
    tick();
    chk("wd_idle", busy, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NC; k++) begin
        if (!req[k] && ($urandom % 4) == 0)
          post(k, 1'($urandom), 16'($urandom), 8'($urandom));
        else if (req[k] && ($urandom % 97) == 0)
          req[k] = 1'b0;
      end
      tick();
    end
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
